user_la_stream_tx: RTL and testbench
====================================

# user_la_stream_tx

- Streams 32-bit words from user-project logic to the management SoC over the logic analyzer (LA) bus.
- Words are buffered in a small FIFO and presented one at a time on `la_data_out`.
- Each word is handed over with a two-phase toggle handshake that firmware completes through `la_data_in`.
- Sits inside the user project, on the opposite side of the LA port from the management core that polls it.

## Interface
- `DEPTH`, 8, FIFO depth in words; power of two, 2..128.
- `wb_clk_i`  in  1  block clock.
- `resetb`  in  1  asynchronous active-low reset.
- `tx_data`  in  32  word from user logic.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  FIFO can accept; a word is pushed when `tx_valid & tx_ready`.
- `la_data_in`  in  128  management-driven LA bits; `[32]` ack toggle, `[33]` enable, `[34]` flush; rest ignored.
- `la_oenb`  in  128  LA output-enable-bar; a `la_data_in` bit is honoured only when its `la_oenb` bit is 0.
- `la_data_out`  out  128  fields, in order:
  - `[31:0]` presented word
  - `[32]` req toggle
  - `[33]` FIFO empty
  - `[34]` FIFO full
  - `[39:35]` zero
  - `[47:40]` fill level
  - `[63:48]` sequence count
  - `[127:64]` zero

## Operation
- Effective controls:
  - `ack_raw = la_oenb[32] ? ack_s : la_data_in[32]`. A masked ack holds its synchronized value.
  - `en_raw = ~la_oenb[33] & la_data_in[33]`.
  - `fl_raw = ~la_oenb[34] & la_data_in[34]`.
  - All three pass through 2-flop synchronizers, giving `ack_s`, `en_s` and `fl_s`.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(DEPTH).
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - `tx_ready = ~full & ~fl_s`.
  - Fill level is zero-extended into 8 bits.
- Flush: while `fl_s` = 1, the FIFO is emptied (read pointer set to the write pointer) and pushes are refused. The word currently presented is not affected.
- State machine, two states:
  - IDLE → PRESENT when `en_s` & ~empty & ~`fl_s`. On that edge: load the FIFO head into `la_data_out[31:0]`, pop it, and invert `req`.
  - PRESENT → IDLE when `ack_s == req`. On that edge the sequence count increments (mod 2^16).
  - `en_s` going low in PRESENT does not abort; the current word completes and no new word starts.
- `la_data_out[31:0]` changes only on an IDLE→PRESENT edge. It is stable for the whole PRESENT interval and keeps the last word while IDLE.
- Simultaneous push and pop on one edge: both take effect, and the fill level is unchanged.
- A push while full cannot occur (`tx_ready` = 0); no overflow path exists.

## Timing
- Reset values, async on `resetb` low:
  - `la_data_out` = 0 except `[33]` = 1 (empty).
  - `tx_ready` = 1 after release. It is combinational from full/`fl_s`, which are both 0 in reset.
  - `req`, `ack_s`, `en_s`, `fl_s` = 0, state IDLE, pointers 0, sequence count 0.
- Push at edge E: empty/fill level update at E. If IDLE and `en_s`, the word and `req` toggle appear at E+1.
- Ack toggled by firmware before edge A: `ack_s` reflects it after edge A+1. The PRESENT→IDLE edge is A+2, and the next word appears at A+3 at the earliest.
- Minimum 3 cycles per word after ack; throughput is bounded by firmware polling.
- Enable and flush take effect 2 edges after the LA bit changes.
- Reset asserted mid-PRESENT: all state returns to reset values and in-flight and buffered words are lost. Firmware must re-read `req` (0) and set its ack to 0 before re-enabling.

## Configuration
- `LA_TX_SEQNUM_EN` defined: `la_data_out[63:48]` carries the 16-bit completed-word count.
- `LA_TX_SEQNUM_EN` undefined: the counter is not built and `[63:48]` read 0.
- No other behaviour changes with the macro.

## Test plan
- Reset then idle, `la_oenb` all 1 → `la_data_out` = 0 except bit 33 = 1; `tx_ready` = 1; no req toggles for 20 cycles.
- Enable, push 0xDEADBEEF → one edge later `[31:0]` = 0xDEADBEEF and `req` = 1. Ack = 1 → after 3 edges, state is IDLE and the sequence count is 1 (macro on).
- DEPTH=8, enable off, push 9 words 0x1..0x9 → `tx_ready` drops after 8, full = 1, fill = 8. Enable, ack each → words appear in order 0x1..0x8, then 0x9.
- Hold `la_oenb[32]` = 1 while toggling `la_data_in[32]` → req stays pending and the word stays stable. Clear `oenb` → handshake completes.
- Flush with 5 words queued while PRESENT with word 0xA → fill level goes to 0 after 2 edges and `tx_ready` = 0 while flush is held. 0xA remains presented until acked.
- Assert `resetb` low mid-PRESENT with 3 words queued → all outputs return to reset values immediately. After release, a push of 0x55 is the next word presented with `req` = 1.

Source files
------------

// File: rtl/user_la_stream_tx.sv
// Buffers 32-bit words from user logic and hands them, one at a time, to firmware over the LA bus using a req/ack toggle handshake.
// Define LA_TX_SEQNUM_EN to build the completed-word counter that appears on la_data_out[63:48].
module user_la_stream_tx #(
  parameter int DEPTH = 8
) (
  input  logic         wb_clk_i,
  input  logic         resetb,
  input  logic [31:0]  tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_e;

  // Control synchronizers; bit [1] of each pair is the synchronized value.
  logic [1:0] ack_sync_q, en_sync_q, fl_sync_q;
  logic       ack_s, en_s, fl_s;
  logic       ack_raw, en_raw, fl_raw;

  // A masked ack feeds back its own synchronized value so it holds steady.
  assign ack_raw = la_oenb[32] ? ack_s : la_data_in[32];
  assign en_raw  = ~la_oenb[33] & la_data_in[33];
  assign fl_raw  = ~la_oenb[34] & la_data_in[34];

  assign ack_s = ack_sync_q[1];
  assign en_s  = en_sync_q[1];
  assign fl_s  = fl_sync_q[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      ack_sync_q <= '0;
      en_sync_q  <= '0;
      fl_sync_q  <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[0], ack_raw};
      en_sync_q  <= {en_sync_q[0], en_raw};
      fl_sync_q  <= {fl_sync_q[0], fl_raw};
    end
  end

  // FIFO storage and pointers (one extra wrap bit).
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic [AW:0] rd_ptr;
  logic [AW:0] fill_cnt;
  logic        empty, full, push, pop;

  // While flushing, the FIFO already reads as empty so fill and full respond with fl_s.
  assign rd_ptr   = fl_s ? wptr_q : rptr_q;
  assign empty    = (wptr_q == rd_ptr);
  assign full     = (wptr_q[AW] != rd_ptr[AW]) && (wptr_q[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill_cnt = wptr_q - rd_ptr;
  assign tx_ready = ~full & ~fl_s;
  assign push     = tx_valid & tx_ready;

  // NOTE: the storage array has no reset; pointers alone define which entries are valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (fl_s)     rptr_q <= wptr_q;
      else if (pop) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Handshake state machine.
  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] word_q, word_d;
  logic        done;

  assign done = (state_q == ST_PRESENT) && (ack_s == req_q);

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_s && !empty && !fl_s) begin
          pop     = 1'b1;
          word_d  = mem_q[rd_ptr[AW-1:0]];
          req_d   = ~req_q;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (done) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      word_q  <= word_d;
    end
  end

`ifdef LA_TX_SEQNUM_EN
  logic [15:0] seq_q;

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb)   seq_q <= '0;
    else if (done) seq_q <= seq_q + 16'd1;
  end
`endif

  always_comb begin
    la_data_out        = '0;
    la_data_out[31:0]  = word_q;
    la_data_out[32]    = req_q;
    la_data_out[33]    = empty;
    la_data_out[34]    = full;
    la_data_out[47:40] = 8'(fill_cnt);
`ifdef LA_TX_SEQNUM_EN
    la_data_out[63:48] = seq_q;
`endif
  end

  // Only bits 32..34 of the LA inputs carry controls.
  logic unused_la_bits;
  assign unused_la_bits = ^{la_data_in[127:35], la_data_in[31:0], la_oenb[127:35], la_oenb[31:0]};

endmodule

// File: tb/tb_user_la_stream_tx.sv
// Self-checking bench for user_la_stream_tx: scoreboard of pushed words against presented words, table-driven fill checks
// and hand-written sequences for masking, flush, simultaneous push/pop and mid-transfer reset.
module tb_user_la_stream_tx;

  logic         clk;
  logic         resetb;
  logic [31:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;

  user_la_stream_tx #(.DEPTH(8)) dut (
    .wb_clk_i    (clk),
    .resetb      (resetb),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        prev_req = 1'b0;
  logic [31:0] prev_word = '0;
  logic [15:0] exp_seq = '0;

  typedef struct {
    logic [31:0] data;
    logic        ready;
    logic        empty;
    logic        full;
    logic [7:0]  fill;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] seq_view(input logic [15:0] s);
`ifdef LA_TX_SEQNUM_EN
    return s;
`else
    return s & 16'h0;
`endif
  endfunction

  function automatic logic [127:0] exp_out(input logic [31:0] w, input logic r, input logic e,
                                           input logic f, input logic [7:0] fl, input logic [15:0] s);
    logic [127:0] v;
    v          = '0;
    v[31:0]    = w;
    v[32]      = r;
    v[33]      = e;
    v[34]      = f;
    v[47:40]   = fl;
    v[63:48]   = seq_view(s);
    return v;
  endfunction

  // One clock: record any accepted push, then compare whatever the DUT presents.
  task automatic step();
    if (tx_valid && tx_ready) exp_q.push_back(tx_data);
    @(posedge clk);
    #1;
    if (la_data_out[32] !== prev_req) begin
      prev_req = la_data_out[32];
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got word %h, expected no new word", la_data_out[31:0]);
      end else begin
        check("word_order", la_data_out[31:0], exp_q.pop_front());
      end
    end else begin
      check("word_stable", la_data_out[31:0], prev_word);
    end
    prev_word = la_data_out[31:0];
  endtask

  task automatic push_word(input logic [31:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic set_en(input logic en);
    la_oenb[33]    = 1'b0;
    la_data_in[33] = en;
    step();
    step();
  endtask

  // Firmware acks the current req; completion lands on the third edge.
  task automatic ack_word();
    la_oenb[32]    = 1'b0;
    la_data_in[32] = la_data_out[32];
    step();
    step();
    check("seq_before_done", la_data_out[63:48], seq_view(exp_seq));
    step();
    exp_seq++;
    check("seq_after_done", la_data_out[63:48], seq_view(exp_seq));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saved_req;

    for (int i = 0; i < 9; i++) begin
      vecs[i].data  = 32'(i + 1);
      vecs[i].fill  = (i < 8) ? 8'(i + 1) : 8'd8;
      vecs[i].full  = (i >= 7);
      vecs[i].ready = (i < 7);
      vecs[i].empty = 1'b0;
    end

    tx_data    = '0;
    tx_valid   = 1'b0;
    la_data_in = '0;
    la_oenb    = '1;
    resetb     = 1'b1;
    #2 resetb  = 1'b0;
    #1;
    check("reset_out", la_data_out, exp_out(32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0));
    check("reset_ready", tx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #3 resetb = 1'b1;

    // Idle with everything masked: no req toggles.
    repeat (20) step();
    check("idle_out", la_data_out, exp_out(32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0));
    check("idle_ready", tx_ready, 1'b1);

    // Single word through the full handshake.
    set_en(1'b1);
    push_word(32'hDEADBEEF);
    check("push_fill", la_data_out, exp_out(32'h0, 1'b0, 1'b0, 1'b0, 8'd1, 16'd0));
    step();
    check("present_first", la_data_out, exp_out(32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 8'd0, 16'd0));
    ack_word();

    // Fill to full with enable off (table-driven).
    set_en(1'b0);
    for (int i = 0; i < 9; i++) begin
      tx_valid = 1'b1;
      tx_data  = vecs[i].data;
      step();
      check("tbl_ready", tx_ready, vecs[i].ready);
      check("tbl_empty", la_data_out[33], vecs[i].empty);
      check("tbl_full", la_data_out[34], vecs[i].full);
      check("tbl_fill", la_data_out[47:40], vecs[i].fill);
    end
    // Word 0x9 stays offered and enters once the first pop frees a slot.
    set_en(1'b1);
    step();
    step();
    tx_valid = 1'b0;
    check("backlog", exp_q.size(), 8);
    for (int i = 0; i < 9; i++) begin
      ack_word();
      step();
    end
    check("drain_order", exp_q.size(), 0);
    check("drained_out", la_data_out, exp_out(32'h9, la_data_out[32] ^ 1'b0 ? 1'b1 : 1'b0, 1'b1, 1'b0, 8'd0, exp_seq));

    // Push and pop on the same edge leave the fill level unchanged.
    set_en(1'b0);
    push_word(32'hA1);
    push_word(32'hA2);
    la_data_in[33] = 1'b1;
    step();
    step();
    check("pp_fill_before", la_data_out[47:40], 8'd2);
    tx_valid = 1'b1;
    tx_data  = 32'hA3;
    step();
    tx_valid = 1'b0;
    check("pp_fill_after", la_data_out[47:40], 8'd2);
    check("pp_word", la_data_out[31:0], 32'hA1);
    for (int i = 0; i < 3; i++) begin
      ack_word();
      step();
    end
    check("pp_drain", exp_q.size(), 0);

    // Masked ack holds the handshake open.
    push_word(32'h12345678);
    step();
    push_word(32'h99990000);
    saved_req      = la_data_out[32];
    la_oenb[32]    = 1'b1;
    la_data_in[32] = saved_req;
    repeat (6) step();
    check("mask_req", la_data_out[32], saved_req);
    check("mask_word", la_data_out[31:0], 32'h12345678);
    check("mask_fill", la_data_out[47:40], 8'd1);
    check("mask_seq", la_data_out[63:48], seq_view(exp_seq));
    ack_word();
    step();
    check("mask_next", la_data_out[31:0], 32'h99990000);
    ack_word();

    // Flush while presenting: queued words vanish, presented word survives.
    push_word(32'hA);
    step();
    for (int i = 0; i < 5; i++) push_word(32'hB0 + 32'(i));
    check("fl_fill_pre", la_data_out[47:40], 8'd5);
    la_oenb[34]    = 1'b0;
    la_data_in[34] = 1'b1;
    step();
    check("fl_fill_e1", la_data_out[47:40], 8'd5);
    check("fl_ready_e1", tx_ready, 1'b1);
    step();
    exp_q.delete();
    check("fl_out_e2", la_data_out, exp_out(32'hA, la_data_out[32], 1'b1, 1'b0, 8'd0, exp_seq));
    check("fl_ready_e2", tx_ready, 1'b0);
    tx_valid = 1'b1;
    tx_data  = 32'hBAD;
    repeat (3) step();
    tx_valid = 1'b0;
    check("fl_refuse", la_data_out[47:40], 8'd0);
    la_data_in[34] = 1'b0;
    step();
    step();
    check("fl_release_ready", tx_ready, 1'b1);
    ack_word();
    repeat (3) step();
    check("fl_word_kept", la_data_out[31:0], 32'hA);

    // Reset in the middle of a transfer with words queued.
    push_word(32'h61);
    step();
    for (int i = 0; i < 3; i++) push_word(32'h62 + 32'(i));
    resetb = 1'b0;
    #2;
    check("rst_mid_out", la_data_out, exp_out(32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0));
    check("rst_mid_ready", tx_ready, 1'b1);
    la_data_in = '0;
    la_oenb    = '1;
    @(posedge clk);
    @(posedge clk);
    #3 resetb = 1'b1;
    exp_q.delete();
    prev_req  = 1'b0;
    prev_word = '0;
    exp_seq   = '0;
    set_en(1'b1);
    push_word(32'h55);
    step();
    check("rst_after_word", la_data_out[32:0], {1'b1, 32'h55});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
